wbh_boot_req_ctrl: RTL and testbench

//  Generates soft_boot_req for the wbh reset FSM from a keyed software request or a watchdog timeout.

---
 rtl/wbh_boot_req_ctrl_pkg.sv | 14 +
 rtl/wbh_boot_req_ctrl_if.sv | 14 +
 rtl/wbh_boot_req_ctrl_wdog_cnt.sv | 26 ++
 rtl/wbh_boot_req_ctrl.sv | 98 +++++++++
 tb/tb_wbh_boot_req_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/wbh_boot_req_ctrl_pkg.sv
// wbh_boot_pkg: shared types and constants for the wbh boot request controller
// Contents: FSM state enum, reboot cause codes, default keys, register addresses.
package wbh_boot_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SW = 2'b01;
    localparam logic [1:0] CAUSE_WD = 2'b10;
    localparam logic [15:0] BOOT_KEY_DEF = 16'hA5C3;
    localparam logic [15:0] KICK_KEY_DEF = 16'h5A5A;
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_LOAD = 2'd1;
    localparam logic [1:0] A_KICK = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;
endpackage

// File: rtl/wbh_boot_req_ctrl_if.sv
// wbh_boot_req_ctrl_if: register bus between wb_host and the boot request controller
// Signals: reg_cs (held until ack), reg_wr, reg_addr[1:0], reg_be[3:0], reg_wdata[31:0] from master;
//          reg_rdata[31:0] and one-cycle reg_ack from slave.
interface wbh_boot_req_ctrl_if;
    logic        reg_cs;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    modport master (output reg_cs, reg_wr, reg_addr, reg_be, reg_wdata, input reg_rdata, reg_ack);
    modport slave (input reg_cs, reg_wr, reg_addr, reg_be, reg_wdata, output reg_rdata, reg_ack);
endinterface

// File: rtl/wbh_boot_req_ctrl_wdog_cnt.sv
// wbh_wdog_cnt: watchdog down-counter with reload, expiry and early-warning flags
// Ports: clk, e_reset_n (async active-low), en (watchdog enabled), hold (force reload),
//        load[W-1:0] (reload value), expire (enabled and count at zero), warn (enabled and count <= load/4).
module wbh_wdog_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         e_reset_n,
    input  logic         en,
    input  logic         hold,
    input  logic [W-1:0] load,
    output logic         expire,
    output logic         warn
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n)
            cnt <= '0;
        else if (!en || hold)
            cnt <= load;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end
    assign expire = en & (cnt == '0);
    assign warn = en & (cnt <= (load >> 2));
endmodule

// File: rtl/wbh_boot_req_ctrl.sv
// wbh_boot_req_ctrl: raises soft_boot_req from a keyed SW request or watchdog expiry
// Ports: clk, e_reset_n (async active-low), s_reset_n (soft reset from reset FSM),
//        bus (register slave: CTRL/WD_LOAD/KICK/STATUS), soft_boot_req (held level), wd_warn.
module wbh_boot_req_ctrl
    import wbh_boot_pkg::*;
#(
    parameter int          WD_WIDTH = 24,
    parameter logic [15:0] BOOT_KEY = BOOT_KEY_DEF,
    parameter logic [15:0] KICK_KEY = KICK_KEY_DEF
) (
    input  logic                clk,
    input  logic                e_reset_n,
    input  logic                s_reset_n,
    wbh_boot_req_ctrl_if.slave  bus,
    output logic                soft_boot_req,
    output logic                wd_warn
);
    state_t              state;
    logic                wd_en, wd_lock, busy, wd_exp, wd_fire;
    logic                acc, wr_stb, ctrl_wr, load_wr, kick, stat_wr, sw_req;
    logic [WD_WIDTH-1:0] load, be_m;
    logic [1:0]          cause;
    logic [7:0]          rb_cnt;
    logic [31:0]         rd_mux;
    always_comb begin
        acc = bus.reg_cs & ~bus.reg_ack;
        wr_stb = acc & bus.reg_wr;
        ctrl_wr = wr_stb & (bus.reg_addr == A_CTRL);
        load_wr = wr_stb & (bus.reg_addr == A_LOAD);
        stat_wr = wr_stb & (bus.reg_addr == A_STATUS);
        kick = wr_stb & (bus.reg_addr == A_KICK) & (&bus.reg_be) & (bus.reg_wdata[15:0] == KICK_KEY);
        // keyed request needs every byte lane so the key itself is fully written
        sw_req = ctrl_wr & (&bus.reg_be) & bus.reg_wdata[2] & (bus.reg_wdata[31:16] == BOOT_KEY);
        busy = state != IDLE;
        // a kick landing on the expiry cycle reloads instead of firing
        wd_fire = wd_exp & ~busy & ~kick;
        be_m = WD_WIDTH'({{8{bus.reg_be[3]}}, {8{bus.reg_be[2]}}, {8{bus.reg_be[1]}}, {8{bus.reg_be[0]}}});
        rd_mux = bus.reg_addr == A_CTRL   ? {29'h0, busy, wd_lock, wd_en} :
                 bus.reg_addr == A_LOAD   ? 32'(load) :
                 bus.reg_addr == A_STATUS ? {16'h0, rb_cnt, 5'h0, busy, cause} : 32'h0;
    end
    wbh_wdog_cnt #(.W(WD_WIDTH)) u_wdog (
        .clk       (clk),
        .e_reset_n (e_reset_n),
        .en        (wd_en),
        .hold      (~s_reset_n | busy | kick),
        .load      (load),
        .expire    (wd_exp),
        .warn      (wd_warn)
    );
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            bus.reg_ack <= 1'b0;
            bus.reg_rdata <= '0;
            wd_en <= 1'b0;
            wd_lock <= 1'b0;
            load <= '0;
        end else begin
            bus.reg_ack <= acc;
            if (acc && !bus.reg_wr)
                bus.reg_rdata <= rd_mux;
            if (ctrl_wr && bus.reg_be[0] && !wd_lock)
                wd_en <= bus.reg_wdata[0];
            if (ctrl_wr && bus.reg_be[0] && bus.reg_wdata[1])
                wd_lock <= 1'b1;
            if (load_wr && !wd_lock)
                load <= (load & ~be_m) | (WD_WIDTH'(bus.reg_wdata) & be_m);
        end
    end
    // cause and rb_cnt only clear on e_reset_n or a STATUS write, so they survive soft resets
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            state <= IDLE;
            soft_boot_req <= 1'b0;
            cause <= CAUSE_NONE;
            rb_cnt <= '0;
        end else begin
            if (stat_wr) begin
                cause <= CAUSE_NONE;
                rb_cnt <= '0;
            end
            unique case (state)
                IDLE: if (sw_req || wd_fire) begin
                    soft_boot_req <= 1'b1;
                    cause <= sw_req ? CAUSE_SW : CAUSE_WD;
                    rb_cnt <= rb_cnt + {7'h0, rb_cnt != 8'hFF};
                    state <= REQ;
                end
                REQ: if (!s_reset_n) begin
                    soft_boot_req <= 1'b0;
                    state <= WAIT_REL;
                end
                WAIT_REL: if (s_reset_n) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wbh_boot_req_ctrl.sv
// tb_wbh_boot_req_ctrl: directed self-checking bench for wbh_boot_req_ctrl
module tb_wbh_boot_req_ctrl;
    import wbh_boot_pkg::*;
    logic clk = 1'b0;
    logic e_reset_n, s_reset_n, soft_boot_req, wd_warn;
    int total = 0;
    int bad = 0;
    int first_warn, req_at;
    wbh_boot_req_ctrl_if bus ();
    wbh_boot_req_ctrl dut (
        .clk           (clk),
        .e_reset_n     (e_reset_n),
        .s_reset_n     (s_reset_n),
        .bus           (bus),
        .soft_boot_req (soft_boot_req),
        .wd_warn       (wd_warn)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] wd, input logic [3:0] b,
                        output logic [31:0] rdat);
        logic ok;
        ok = 1'b0;
        bus.reg_cs = 1'b1;
        bus.reg_wr = w;
        bus.reg_addr = a;
        bus.reg_wdata = wd;
        bus.reg_be = b;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = bus.reg_ack;
        end
        rdat = bus.reg_rdata;
        bus.reg_cs = 1'b0;
        bus.reg_wr = 1'b0;
        chk("ack_seen", 32'(ok), 32'd1);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] dummy;
        xfer(1'b1, a, wd, b, dummy);
    endtask
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        xfer(1'b0, a, 32'h0, 4'h0, got);
        chk(tag, got, exp);
    endtask
    task automatic handshake();
        s_reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("req_drop", 32'(soft_boot_req), 32'd0);
        s_reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        e_reset_n = 1'b0;
        s_reset_n = 1'b1;
        bus.reg_cs = 1'b0;
        bus.reg_wr = 1'b0;
        bus.reg_addr = 2'd0;
        bus.reg_be = 4'h0;
        bus.reg_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(soft_boot_req), 32'd0);
        chk("rst_warn", 32'(wd_warn), 32'd0);
        chk("rst_ack", 32'(bus.reg_ack), 32'd0);
        chk("rst_rdata", bus.reg_rdata, 32'h0);
        e_reset_n = 1'b1;
        rd(A_STATUS, 32'h0, "status_rst");
        rd(A_CTRL, 32'h0, "ctrl_rst");
        rd(A_LOAD, 32'h0, "load_rst");
        // keyed SW request
        wr(A_CTRL, 32'hA5C3_0004, 4'hF);
        chk("sw_req", 32'(soft_boot_req), 32'd1);
        rd(A_CTRL, 32'h4, "ctrl_busy");
        handshake();
        rd(A_STATUS, 32'h0000_0101, "status_sw");
        // wrong key and partial byte enables drop the request
        wr(A_CTRL, 32'h1234_0004, 4'hF);
        wr(A_CTRL, 32'hA5C3_0004, 4'h1);
        @(posedge clk);
        #1;
        chk("bad_key_req", 32'(soft_boot_req), 32'd0);
        bus.reg_cs = 1'b1;
        bus.reg_wr = 1'b1;
        bus.reg_addr = A_CTRL;
        bus.reg_wdata = 32'h1234_0004;
        bus.reg_be = 4'hF;
        @(posedge clk);
        #1;
        chk("ack_pulse_hi", 32'(bus.reg_ack), 32'd1);
        @(posedge clk);
        #1;
        chk("ack_pulse_lo", 32'(bus.reg_ack), 32'd0);
        bus.reg_cs = 1'b0;
        bus.reg_wr = 1'b0;
        rd(A_STATUS, 32'h0000_0101, "status_unchanged");
        // watchdog expiry
        wr(A_LOAD, 32'd100, 4'hF);
        rd(A_LOAD, 32'd100, "load_rd");
        wr(A_CTRL, 32'h1, 4'hF);
        first_warn = 0;
        req_at = 0;
        for (int n = 1; n <= 200 && req_at == 0; n++) begin
            @(posedge clk);
            #1;
            if (wd_warn && first_warn == 0) first_warn = n;
            if (soft_boot_req) req_at = n;
        end
        chk("warn_cycle", 32'(first_warn), 32'd75);
        chk("wd_req_cycle", 32'(req_at), 32'd101);
        rd(A_STATUS, 32'h0000_0206, "status_wd_busy");
        handshake();
        rd(A_STATUS, 32'h0000_0202, "status_wd");
        // periodic kicks keep the watchdog quiet
        for (int k = 0; k < 20; k++) begin
            wr(A_KICK, 32'h0000_5A5A, 4'hF);
            repeat (48) @(posedge clk);
            #1;
        end
        chk("kick_no_req", 32'(soft_boot_req), 32'd0);
        rd(A_STATUS, 32'h0000_0202, "status_kicked");
        wr(A_KICK, 32'h0000_5A5A, 4'hF);
        repeat (59) @(posedge clk);
        #1;
        wr(A_KICK, 32'h0000_0000, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        chk("warn_on", 32'(wd_warn), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        chk("bad_kick_req", 32'(soft_boot_req), 32'd1);
        rd(A_STATUS, 32'h0000_0306, "status_bad_kick");
        handshake();
        // lock freezes wd_en and WD_LOAD
        wr(A_CTRL, 32'h3, 4'hF);
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_LOAD, 32'd5, 4'hF);
        rd(A_CTRL, 32'h3, "lock_en");
        rd(A_LOAD, 32'd100, "lock_load");
        e_reset_n = 1'b0;
        #1;
        chk("erst_req", 32'(soft_boot_req), 32'd0);
        chk("erst_warn", 32'(wd_warn), 32'd0);
        @(posedge clk);
        #1;
        e_reset_n = 1'b1;
        rd(A_CTRL, 32'h0, "unlock_ctrl");
        rd(A_LOAD, 32'h0, "unlock_load");
        rd(A_STATUS, 32'h0, "unlock_status");
        wr(A_LOAD, 32'h0012_3456, 4'b0010);
        rd(A_LOAD, 32'h0000_3400, "load_be");
        wr(A_LOAD, 32'hFFFF_FFFF, 4'hF);
        rd(A_LOAD, 32'h00FF_FFFF, "load_zext");
        wr(A_LOAD, 32'h0, 4'hF);
        // enabling with load 0 fires one cycle later
        wr(A_CTRL, 32'h1, 4'hF);
        chk("load0_wait", 32'(soft_boot_req), 32'd0);
        @(posedge clk);
        #1;
        chk("load0_fire", 32'(soft_boot_req), 32'd1);
        rd(A_STATUS, 32'h0000_0106, "status_load0");
        wr(A_CTRL, 32'h0, 4'hF);
        handshake();
        // requests while busy are dropped, rb_cnt saturates
        wr(A_CTRL, 32'hA5C3_0004, 4'hF);
        wr(A_CTRL, 32'hA5C3_0004, 4'hF);
        rd(A_STATUS, 32'h0000_0205, "status_drop_busy");
        handshake();
        rd(A_STATUS, 32'h0000_0201, "status_after_drop");
        for (int i = 0; i < 300; i++) begin
            wr(A_CTRL, 32'hA5C3_0004, 4'hF);
            handshake();
        end
        rd(A_STATUS, 32'h0000_FF01, "rb_sat");
        wr(A_STATUS, 32'h0, 4'hF);
        rd(A_STATUS, 32'h0, "status_clear");
        wr(A_CTRL, 32'hA5C3_0004, 4'hF);
        chk("req_before_erst", 32'(soft_boot_req), 32'd1);
        e_reset_n = 1'b0;
        #1;
        chk("erst_mid_req", 32'(soft_boot_req), 32'd0);
        @(posedge clk);
        #1;
        e_reset_n = 1'b1;
        rd(A_STATUS, 32'h0, "erst_status");
        rd(A_CTRL, 32'h0, "erst_ctrl");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
